// File: rtl/uart_rx_fifo.sv
// UART receiver with a receive FIFO, sticky error flags and a double-rate bit-period select.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int FREQ_HZ    = 25_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic                          fsel,
    input  logic                          rd,
    output logic                          rdy,
    output logic [7:0]                    data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int P_FULL = FREQ_HZ / BAUD_RATE;
    localparam int P_HALF = P_FULL / 2;
    localparam int TW     = $clog2(P_FULL + 1);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int BW     = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] P_FULL_T = TW'(P_FULL);
    localparam logic [TW-1:0] P_HALF_T = TW'(P_HALF);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_s1_q, rx_s1_d;
    logic                   rx_s2_q, rx_s2_d;
    logic                   rx_prev_q, rx_prev_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [TW-1:0]          per_q, per_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic                   parity_err_q, parity_err_d;
    logic                   par_bad_q, par_bad_d;
    logic                   perr_evt;
`endif

    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                   wr_req;
    logic                   ferr_evt;
    logic                   ovr_evt;
    logic                   do_wr;
    logic                   do_rd;
    logic                   full;
    logic                   empty;
    logic                   at_end;

    always_comb begin
        state_d     = state_q;
        rx_s1_d     = rxd;
        rx_s2_d     = rx_s1_q;
        rx_prev_d   = rx_s2_q;
        tick_d      = tick_q + TW'(1);
        per_d       = per_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wr_req      = 1'b0;
        ferr_evt    = 1'b0;
        at_end      = (tick_q == per_q - TW'(1));
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        perr_evt    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                tick_d    = '0;
                bit_cnt_d = '0;
                per_d     = fsel ? P_HALF_T : P_FULL_T;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (rx_prev_q && !rx_s2_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Mid-start-bit resample: a line already back high was a glitch.
                if (tick_q == (per_q >> 1)) begin
                    tick_d  = '0;
                    state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_end) begin
                    tick_d    = '0;
                    shift_d   = {rx_s2_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (at_end) begin
                    tick_d    = '0;
                    state_d   = ST_STOP;
                    par_bad_d = rx_s2_q ^ (^shift_q) ^ PAR_ODD;
                    perr_evt  = par_bad_d;
                end
            end
`endif
            ST_STOP: begin
                if (at_end) begin
                    tick_d  = '0;
                    state_d = ST_IDLE;
                    if (!rx_s2_q) begin
                        ferr_evt = 1'b1;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        wr_req = !par_bad_q;
`else
                        wr_req = 1'b1;
`endif
                    end
                end
            end
            default: begin
                tick_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A full FIFO still accepts a frame when the same cycle pops the head.
    always_comb begin
        full     = (count_q == DEPTH_C);
        empty    = (count_q == '0);
        do_rd    = rd && !empty;
        do_wr    = wr_req && (!full || rd);
        ovr_evt  = wr_req && full && !rd;
        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        frame_err_d  = (frame_err_q && !err_clr) || ferr_evt;
        overrun_d    = (overrun_q && !err_clr) || ovr_evt;
`ifdef UART_RX_PARITY_EN
        parity_err_d = (parity_err_q && !err_clr) || perr_evt;
`endif
    end

    // Synchronizer resets low so a line held low through reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rx_s1_q      <= 1'b0;
            rx_s2_q      <= 1'b0;
            rx_prev_q    <= 1'b0;
            tick_q       <= '0;
            per_q        <= P_FULL_T;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rx_s1_q      <= rx_s1_d;
            rx_s2_q      <= rx_s2_d;
            rx_prev_q    <= rx_prev_d;
            tick_q       <= tick_d;
            per_q        <= per_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
            par_bad_q    <= par_bad_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rdy       = !empty;
    assign data      = rdy ? 8'(mem_q[rd_ptr_q]) : 8'h00;
    assign count     = count_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are driven bit by bit on the falling clock edge,
// outputs are checked on the falling edge against hand-computed values.
module tb_uart_rx_fifo;

    localparam int FREQ   = 25_000_000;
    localparam int BAUD   = 115_200;
    localparam int DB     = 8;
    localparam int DEPTH  = 16;
    localparam int P_FULL = FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       fsel;
    logic       rd;
    logic       err_clr;
    logic       rdy;
    logic [7:0] data;
    logic [4:0] count;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int per;

    uart_rx_fifo #(
        .FREQ_HZ    (FREQ),
        .BAUD_RATE  (BAUD),
        .DATA_BITS  (DB),
        .FIFO_DEPTH (DEPTH),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .fsel       (fsel),
        .rd         (rd),
        .rdy        (rdy),
        .data       (data),
        .count      (count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Negedge index (from frame start) of the cycle in which the stop bit is sampled.
    function automatic int wr_cycle();
        return 3 + per / 2 + (DB + PB + 1) * per;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                              input int rd_at, input bit chk_wr, input int len);
        int   total;
        int   lim;
        int   ws;
        int   k;
        logic bitv;
        total = (DB + PB + 2) * per;
        lim   = (len > 0) ? len : total;
        ws    = wr_cycle();
        for (int c = 0; c < lim; c++) begin
            @(negedge clk);
            k = c / per;
            if (k == 0)                          bitv = 1'b0;
            else if (k <= DB)                    bitv = b[k-1];
            else if (PB == 1 && k == DB + 1)     bitv = (^b) ^ par_flip;
            else                                 bitv = stop_bit;
            rxd = bitv;
            rd  = (c == rd_at);
            if (chk_wr && c == ws)     check("count_before_write", 32'(count), 32'd0);
            if (chk_wr && c == ws + 1) check("rdy_after_write", 32'(rdy), 32'd1);
        end
        if (len == 0) begin
            @(negedge clk);
            rxd = 1'b1;
            rd  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pop();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        rxd     = 1'b1;
        fsel    = 1'b0;
        rd      = 1'b0;
        err_clr = 1'b0;
        per     = P_FULL;
        repeat (3) @(negedge clk);
        check("reset_rdy", 32'(rdy), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_data", 32'(data), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic 8N1 frame, with write timing checked around the stop sample
        send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b1, 0);
        check("a5_rdy", 32'(rdy), 32'd1);
        check("a5_data", 32'(data), 32'hA5);
        check("a5_count", 32'(count), 32'd1);
        pop();
        check("a5_pop_rdy", 32'(rdy), 32'd0);
        check("a5_pop_count", 32'(count), 32'd0);

        // Short low glitch is rejected, then a real frame still decodes
        @(negedge clk);
        rxd = 1'b0;
        repeat (P_FULL / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * P_FULL) @(negedge clk);
        check("glitch_count", 32'(count), 32'd0);
        check("glitch_rdy", 32'(rdy), 32'd0);
        check("glitch_frame_err", 32'(frame_err), 32'd0);
        send_frame(8'h33, 1'b1, 1'b0, -1, 1'b0, 0);
        check("after_glitch_data", 32'(data), 32'h33);
        check("after_glitch_count", 32'(count), 32'd1);

        // Simultaneous write and pop with one entry held
        send_frame(8'h44, 1'b1, 1'b0, wr_cycle(), 1'b0, 0);
        check("wr_rd_count", 32'(count), 32'd1);
        check("wr_rd_data", 32'(data), 32'h44);
        pop();
        check("wr_rd_pop_count", 32'(count), 32'd0);

        // Pop on empty is ignored
        @(negedge clk);
        rd = 1'b1;
        repeat (3) @(negedge clk);
        rd = 1'b0;
        check("empty_pop_count", 32'(count), 32'd0);
        check("empty_pop_rdy", 32'(rdy), 32'd0);

        // Stop bit low: frame error, nothing written, cleared by err_clr
        send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0, 0);
        check("ferr_set", 32'(frame_err), 32'd1);
        check("ferr_count", 32'(count), 32'd0);
        check("ferr_parity_err", 32'(parity_err), 32'd0);
        @(negedge clk);
        err_clr = 1'b1;
        check("ferr_hold_before_edge", 32'(frame_err), 32'd1);
        @(negedge clk);
        err_clr = 1'b0;
        check("ferr_cleared", 32'(frame_err), 32'd0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1, -1, 1'b0, 0);
        check("perr_set", 32'(parity_err), 32'd1);
        check("perr_count", 32'(count), 32'd0);
        send_frame(8'h01, 1'b1, 1'b0, -1, 1'b0, 0);
        check("par_ok_data", 32'(data), 32'h01);
        check("par_ok_count", 32'(count), 32'd1);
        pop();
        clear_errs();
        check("perr_cleared", 32'(parity_err), 32'd0);
`endif

        // Double-rate period, fill past depth
        fsel = 1'b1;
        per  = P_FULL / 2;
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, -1, 1'b0, 0);
        end
        check("fill_count", 32'(count), 32'd16);
        check("fill_overrun", 32'(overrun), 32'd0);
        send_frame(8'h10, 1'b1, 1'b0, -1, 1'b0, 0);
        check("ovr_count", 32'(count), 32'd16);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_head", 32'(data), 32'h00);
        clear_errs();
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Write on full with same-cycle pop is accepted
        send_frame(8'h55, 1'b1, 1'b0, wr_cycle(), 1'b0, 0);
        check("full_wr_rd_count", 32'(count), 32'd16);
        check("full_wr_rd_overrun", 32'(overrun), 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain_data", 32'(data), (i < DEPTH) ? 32'(i) : 32'h55);
            pop();
        end
        check("drain_count", 32'(count), 32'd0);
        check("drain_rdy", 32'(rdy), 32'd0);
        fsel = 1'b0;
        per  = P_FULL;

        // Reset in the middle of data bit 4
        send_frame(8'h77, 1'b1, 1'b0, -1, 1'b0, 0);
        send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0, 0);
        check("pre_rst_count", 32'(count), 32'd1);
        check("pre_rst_frame_err", 32'(frame_err), 32'd1);
        send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b0, 5 * per + per / 2);
        rst = 1'b1;
        #1;
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (12 * per) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * per) @(negedge clk);
        check("low_after_rst_count", 32'(count), 32'd0);
        check("low_after_rst_frame_err", 32'(frame_err), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b0, 0);
        check("post_rst_data", 32'(data), 32'h5A);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_frame_err", 32'(frame_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter FREQ_HZ, default 25_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200, meaning the nominal line rate.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..8).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (power of two, 2..256).
REQ-005 The block SHALL have parameter PARITY_ODD, default 0, meaning odd parity when 1 and even parity when 0 (used only with UART_RX_PARITY_EN).
REQ-006 The block SHALL have ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rxd  in  1  asynchronous serial line, idle high.
- fsel  in  1  double-rate select; bit period = (FREQ_HZ/BAUD_RATE)/2 when 1.
- rd  in  1  pop strobe, one entry per cycle asserted.
- rdy  out  1  FIFO not empty.
- data  out  8  head entry, zero-extended above DATA_BITS.
- count  out  $clog2(FIFO_DEPTH)+1  entries held.
- frame_err  out  1  sticky: stop bit sampled low.
- parity_err  out  1  sticky: parity mismatch.
- overrun  out  1  sticky: frame dropped on full FIFO.
- err_clr  in  1  clears all sticky flags.

Function
REQ-007 rxd SHALL pass a two-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-008 Bit period P SHALL be FREQ_HZ/BAUD_RATE (integer division), halved (floor) when fsel=1; fsel SHALL be sampled only in IDLE.
REQ-009 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-010 IDLE->START SHALL occur on a synchronized high-to-low transition; the tick counter SHALL restart at 0.
REQ-011 In START, at tick P/2 the line SHALL be resampled: low -> DATA with tick reset; high -> IDLE (glitch rejection, nothing written).
REQ-012 In DATA, each bit SHALL be sampled when the tick counter reaches P-1 after the previous sample, LSB first, DATA_BITS samples total.
REQ-013 After the last data bit the FSM SHALL go to PARITY when parity is compiled in, else STOP.
REQ-014 In STOP, one sample SHALL be taken at P-1; the FSM SHALL then return to IDLE on the same cycle.
REQ-015 A frame with stop sample low SHALL set frame_err and SHALL NOT be written.
REQ-016 A good frame SHALL be written at the stop sample cycle; rdy and count SHALL update on the next cycle.
REQ-017 A write when the FIFO is full and rd is low SHALL be discarded and SHALL set overrun.
REQ-018 A write while full with rd high in the same cycle SHALL be accepted; count SHALL stay FIFO_DEPTH.
REQ-019 Simultaneous write and read when not full SHALL leave count unchanged.
REQ-020 rd while empty SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 data SHALL show the head entry combinationally from pointer state; its value is undefined while rdy=0.
REQ-022 err_clr SHALL clear the sticky flags on the next edge; a new error event in the same cycle SHALL win (flag stays set).

Reset
REQ-023 rst high SHALL immediately force state IDLE, tick, bit count, and pointers to 0, and rdy, count, frame_err, parity_err, and overrun to 0, regardless of any frame in progress.
REQ-024 After rst deasserts, a line already low SHALL NOT start a frame until a fresh high-to-low transition occurs.

Configuration
REQ-025 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL sample one parity bit at P-1; a mismatch against PARITY_ODD SHALL set parity_err and drop the frame.
REQ-026 Without UART_RX_PARITY_EN, the PARITY state and parity logic SHALL be absent, and parity_err SHALL be constant 0.

Verification
REQ-027 8N1 at 115200/25 MHz: send 0xA5 -> one cycle after stop sample, rdy=1, data=0xA5, count=1; then rd pulse -> rdy=0.
REQ-028 Pulse rxd low for P/4 cycles -> no write, state back to IDLE, count=0.
REQ-029 Send 17 bytes 0x00..0x10 with no reads (depth 16) -> count=16, overrun=1, reads return 0x00..0x0F in order.
REQ-030 Send 0x3C with stop bit low -> frame_err=1, count=0; err_clr -> frame_err=0 next cycle.
REQ-031 With UART_RX_PARITY_EN and even parity, send 0x01 with parity bit 0 -> parity_err=1, no write; with parity bit 1 -> data=0x01.
REQ-032 Assert rst mid-data-bit 4 of a frame -> all outputs 0 at once; the next clean frame 0x5A is received correctly.
